// File: rtl/robs_control.sv
// Moore control FSM for the signed Robertson multiplier; drives datapath word c[14:0] from zr/zq status.
// Optional `ROBS_CTRL_STATE_OUT_EN adds state_dbg[3:0] exposing the current state encoding.
module robs_control #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        zr,
  input  logic        zq,
  output logic [14:0] c,
  output logic        busy,
  output logic        done
`ifdef ROBS_CTRL_STATE_OUT_EN
  ,
  output logic [3:0]  state_dbg
`endif
);

  if (WIDTH != 8) begin : g_width_check
    $error("robs_control: zq termination requires WIDTH == 8");
  end

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_INIT   = 4'd1;
  localparam logic [3:0] S_LOADR  = 4'd2;
  localparam logic [3:0] S_TEST   = 4'd3;
  localparam logic [3:0] S_DECIDE = 4'd4;
  localparam logic [3:0] S_ADD    = 4'd5;
  localparam logic [3:0] S_SUB    = 4'd6;
  localparam logic [3:0] S_SHIFT  = 4'd7;
  localparam logic [3:0] S_LOADSH = 4'd8;
  localparam logic [3:0] S_FINISH = 4'd9;
  localparam logic [3:0] S_DONE   = 4'd10;

  logic [3:0]  r_state;
  logic [3:0]  w_state_next;
  logic [14:0] r_c;
  logic [14:0] w_c_next;
  logic        r_busy;
  logic        w_busy_next;
  logic        r_done;
  logic        w_done_next;

  // State and output registers; outputs are decoded from the next state so they align with r_state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_c     <= 15'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_c     <= w_c_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE
  always_comb begin
    w_state_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_INIT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_INIT:   w_state_next = S_LOADR;
      S_LOADR:  w_state_next = S_TEST;
      S_TEST:   w_state_next = S_DECIDE;
      S_DECIDE: begin
        if (zr) begin
          w_state_next = S_SHIFT;
        end else if (zq) begin
          w_state_next = S_SUB;
        end else begin
          w_state_next = S_ADD;
        end
      end
      S_ADD:    w_state_next = S_SHIFT;
      S_SUB:    w_state_next = S_SHIFT;
      S_SHIFT:  w_state_next = S_LOADSH;
      S_LOADSH: begin
        if (zq) begin
          w_state_next = S_FINISH;
        end else begin
          w_state_next = S_TEST;
        end
      end
      S_FINISH: w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Control-word decode of the state being entered
  always_comb begin
    w_c_next    = 15'd0;
    w_busy_next = 1'b1;
    w_done_next = 1'b0;
    case (w_state_next)
      S_IDLE:   w_busy_next = 1'b0;
      S_INIT:   w_c_next = 15'h000F;
      S_LOADR:  w_c_next = 15'h0300;
      S_TEST:   w_c_next = 15'h2000;
      S_DECIDE: w_c_next = 15'h0000;
      S_ADD:    w_c_next = 15'h0520;
      S_SUB:    w_c_next = 15'h0120;
      S_SHIFT:  w_c_next = 15'h1800;
      S_LOADSH: w_c_next = 15'h0350;
      S_FINISH: w_c_next = 15'h4088;
      S_DONE:   w_done_next = 1'b1;
      default: begin
        w_c_next    = 15'd0;
        w_busy_next = 1'b0;
      end
    endcase
  end

  assign c    = r_c;
  assign busy = r_busy;
  assign done = r_done;

`ifdef ROBS_CTRL_STATE_OUT_EN
  assign state_dbg = r_state;
`endif

endmodule

// File: tb/tb_robs_control.sv
// Bench for robs_control: a small datapath model closes the zr/zq loop, and the expected
// control-word stream is generated from the multiplier's bit pattern.
module tb_robs_control;

  localparam logic [14:0] C_INIT   = 15'h000F;
  localparam logic [14:0] C_LOADR  = 15'h0300;
  localparam logic [14:0] C_TEST   = 15'h2000;
  localparam logic [14:0] C_ADD    = 15'h0520;
  localparam logic [14:0] C_SUB    = 15'h0120;
  localparam logic [14:0] C_SHIFT  = 15'h1800;
  localparam logic [14:0] C_LOADSH = 15'h0350;
  localparam logic [14:0] C_FINISH = 15'h4088;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        zr;
  logic        zq;
  logic [14:0] c;
  logic        busy;
  logic        done;
`ifdef ROBS_CTRL_STATE_OUT_EN
  logic [3:0]  state_dbg;
`endif

  robs_control dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .zr    (zr),
    .zq    (zq),
    .c     (c),
    .busy  (busy),
    .done  (done)
`ifdef ROBS_CTRL_STATE_OUT_EN
    ,
    .state_dbg (state_dbg)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 0;
  int lat_obs = 0;
  int exp_lat = 0;
  int sub_seen = 0;
  int addsub_seen = 0;
  bit done_seen = 1'b0;
  logic [15:0] prod_obs = 16'h0;
  logic signed [15:0] exp_prod = 16'sh0;
  logic [16:0] exp_q[$];

  // Datapath model: 9-bit high half keeps the true sign through add/sub before the shift
  logic [7:0]  op_mplier = 8'h0;
  logic [7:0]  op_mcand = 8'h0;
  logic [7:0]  m_y = 8'h0;
  logic [7:0]  m_x = 8'h0;
  logic [7:0]  m_q = 8'h0;
  logic [8:0]  m_a = 9'h0;
  logic [16:0] m_r = 17'h0;
  logic [16:0] m_s = 17'h0;
  logic [14:0] c_hold = 15'h0;

  assign zr = ~m_r[0];
  assign zq = (m_q[2:0] == 3'd0);

  always @(negedge clk) c_hold = c;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (c_hold[0]) m_y <= op_mcand;
    if (c_hold[1]) m_q <= 8'd0;
    else if (c_hold[13]) m_q <= m_q - 8'd1;
    if (c_hold[2]) m_a <= 9'd0;
    else if (c_hold[14]) m_a <= m_r[16:8];
    if (c_hold[3]) m_x <= c_hold[7] ? m_r[7:0] : op_mplier;
    if (c_hold[8]) begin
      case (c_hold[5:4])
        2'd0: m_r[16:8] <= m_a;
        2'd1: m_r[16:8] <= m_s[16:8];
        2'd2: m_r[16:8] <= c_hold[10] ? (m_r[16:8] + {m_y[7], m_y}) : (m_r[16:8] - {m_y[7], m_y});
        default: m_r[16:8] <= 9'h0;
      endcase
    end
    if (c_hold[9]) m_r[7:0] <= c_hold[6] ? m_s[7:0] : m_x;
    if (c_hold[12]) m_s <= c_hold[11] ? {m_r[16], m_r[16:1]} : {1'b0, m_r[16:1]};
  end

  // Single compare process: control outputs every cycle, product and latency at done
  always @(negedge clk) begin
    logic [16:0] expw;
    expw = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h0;
    tests++;
    if ({done, busy, c} !== expw) begin
      fails++;
      $display("FAIL ctrl cyc=%0d got done=%b busy=%b c=%h want done=%b busy=%b c=%h",
               cyc, done, busy, c, expw[16], expw[15], expw[14:0]);
    end
    if (c == C_SUB) sub_seen++;
    if (c == C_ADD || c == C_SUB) addsub_seen++;
    if (done === 1'b1) begin
      done_seen = 1'b1;
      lat_obs = cyc - t0 + 1;
      prod_obs = {m_a[7:0], m_x};
      tests++;
      if (prod_obs !== exp_prod) begin
        fails++;
        $display("FAIL model_product got %h want %h", prod_obs, exp_prod);
      end
      tests++;
      if (lat_obs != exp_lat) begin
        fails++;
        $display("FAIL model_latency got %0d want %0d", lat_obs, exp_lat);
      end
    end
  end

  task automatic push_seq(input logic [7:0] mp);
    exp_q.push_back({1'b0, 1'b1, C_INIT});
    exp_q.push_back({1'b0, 1'b1, C_LOADR});
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({1'b0, 1'b1, C_TEST});
      exp_q.push_back({1'b0, 1'b1, 15'h0});
      if (mp[i]) exp_q.push_back({1'b0, 1'b1, (i == 7) ? C_SUB : C_ADD});
      exp_q.push_back({1'b0, 1'b1, C_SHIFT});
      exp_q.push_back({1'b0, 1'b1, C_LOADSH});
    end
    exp_q.push_back({1'b0, 1'b1, C_FINISH});
    exp_q.push_back({1'b1, 1'b1, 15'h0});
  endtask

  task automatic launch(input logic [7:0] mp, input logic [7:0] mc);
    op_mplier = mp;
    op_mcand  = mc;
    exp_prod  = $signed(mp) * $signed(mc);
    exp_lat   = 36 + $countones(mp);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
    sub_seen = 0;
    addsub_seen = 0;
    done_seen = 1'b0;
    push_seq(mp);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] mp, input logic [7:0] mc,
                        input int lit_lat, input logic [15:0] lit_prod,
                        input int lit_sub, input int lit_addsub, input bit poke);
    launch(mp, mc);
    if (poke) begin
      repeat (5) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int k = 0; k < 100 && !done_seen; k++) @(posedge clk);
    #1;
    tests++;
    if (!done_seen) begin
      fails++;
      $display("FAIL %s_timeout got no done want done within 100 cycles", name);
    end
    check_int({name, "_latency"}, lat_obs, lit_lat);
    tests++;
    if (prod_obs !== lit_prod) begin
      fails++;
      $display("FAIL %s_product got %h want %h", name, prod_obs, lit_prod);
    end
    check_int({name, "_sub_visits"}, sub_seen, lit_sub);
    check_int({name, "_addsub_visits"}, addsub_seen, lit_addsub);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_op("m3x5",     8'h03, 8'h05, 38, 16'h000F, 0, 2, 1'b0);
    run_op("mneg3x5",  8'hFD, 8'h05, 43, 16'hFFF1, 1, 7, 1'b0);
    run_op("m128x128", 8'h80, 8'h80, 37, 16'h4000, 1, 1, 1'b0);
    run_op("m0x7f",    8'h00, 8'h7F, 36, 16'h0000, 0, 0, 1'b0);
    run_op("mffx01",   8'hFF, 8'h01, 44, 16'hFFFF, 1, 8, 1'b0);
    run_op("m3x5poke", 8'h03, 8'h05, 38, 16'h000F, 0, 2, 1'b1);

    // Abort mid-operation: outputs must clear in the same cycle as reset
    launch(8'h03, 8'h05);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_int("reset_abort_done_seen", int'(done_seen), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_op("m3x5fresh", 8'h03, 8'h05, 38, 16'h000F, 0, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
